// File: rtl/rom_dl_router_if.sv
// SDRAM write-port bundle between the ROM download router (master) and the sdram controller (slave).
interface rom_dl_router_if #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_AW   = 23
);
    logic [NUM_PORTS-1:0] port_req;
    logic [NUM_PORTS-1:0] port_ack;
    logic [PORT_AW-1:0]   port_a;
    logic [15:0]          port_d;
    logic [1:0]           port_ds;
    logic                 port_we;

    modport master (
        output port_req, port_a, port_d, port_ds, port_we,
        input  port_ack
    );

    modport slave (
        input  port_req, port_a, port_d, port_ds, port_we,
        output port_ack
    );
endinterface

// File: rtl/rom_dl_router.sv
// ROM download router: packs the ioctl byte stream into 16-bit words, routes each word to an sdram
// write port by address region with toggle req/ack handshakes, and produces rom_loaded / core_reset.
module rom_dl_router #(
    parameter int          NUM_PORTS    = 2,
    parameter int          PORT_AW      = 23,
    parameter logic [7:0]  ROM_INDEX    = 8'h00,
    parameter logic [24:0] BASE_0       = 25'h000_0000,
    parameter logic [24:0] BASE_1       = 25'h001_0000,
    parameter logic [24:0] BASE_2       = 25'h002_0000,
    parameter logic [24:0] BASE_3       = 25'h003_0000,
    parameter logic [15:0] RESET_CYCLES = 16'hFFFF
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ioctl_downl,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [24:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    input  logic                  soft_reset,
    rom_dl_router_if.master       sd,
    output logic                  dl_busy,
    output logic                  overflow,
    output logic                  rom_loaded,
    output logic                  core_reset
);
    localparam logic [24:0] BASES [4] = '{BASE_0, BASE_1, BASE_2, BASE_3};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [NUM_PORTS-1:0] sel;
        logic [PORT_AW-1:0]   a;
        logic [15:0]          d;
        logic [1:0]           ds;
    } word_t;

    state_t               state_q, state_d;
    logic                 wr_q, downl_q;
    logic                 asm_valid, asm_valid_d, asm_load;
    logic [NUM_PORTS-1:0] asm_sel;
    logic [PORT_AW-1:0]   asm_a;
    logic [7:0]           asm_byte;
    logic                 slot_full;
    word_t                slot, cw, held_w;
    logic                 cw_valid, extra_drop, issue, ack_done;
    logic [NUM_PORTS-1:0] req_q, cur_sel;
    logic [PORT_AW-1:0]   a_q;
    logic [15:0]          d_q;
    logic [1:0]           ds_q;
    logic                 we_q, overflow_q, dl_seen, rom_loaded_q, core_reset_q;
    logic [15:0]          count_q;
    logic                 byte_hit, same_word, accept, downl_fall, downl_rise;
    logic [NUM_PORTS-1:0] byte_sel;
    logic [24:0]          byte_off;
    logic [PORT_AW-1:0]   byte_a;

    assign accept     = ioctl_wr && !wr_q && ioctl_downl && (ioctl_index == ROM_INDEX);
    assign downl_fall = downl_q && !ioctl_downl;
    assign downl_rise = !downl_q && ioctl_downl;

    // Regions ascend, so the last base the address clears is the highest matching region.
    always_comb begin
        byte_hit = 1'b0;
        byte_sel = '0;
        byte_off = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ioctl_addr >= BASES[i]) begin
                byte_hit    = 1'b1;
                byte_sel    = '0;
                byte_sel[i] = 1'b1;
                byte_off    = ioctl_addr - BASES[i];
            end
        end
    end

    assign byte_a    = byte_off[PORT_AW:1];
    assign same_word = asm_valid && (asm_sel == byte_sel) && (asm_a == byte_a);
    assign held_w    = '{sel: asm_sel, a: asm_a, d: {8'h00, asm_byte}, ds: 2'b01};

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        cw          = '0;
        cw_valid    = 1'b0;
        extra_drop  = 1'b0;
        asm_valid_d = asm_valid;
        asm_load    = 1'b0;
        if (accept && byte_hit) begin
            if (!ioctl_addr[0]) begin
                if (asm_valid && !same_word) begin
                    cw       = held_w;
                    cw_valid = 1'b1;
                end
                asm_valid_d = 1'b1;
                asm_load    = 1'b1;
            end else if (same_word) begin
                cw          = held_w;
                cw.d        = {ioctl_dout, asm_byte};
                cw.ds       = 2'b11;
                cw_valid    = 1'b1;
                asm_valid_d = 1'b0;
            end else begin
                cw_valid    = 1'b1;
                asm_valid_d = 1'b0;
                if (asm_valid) begin
                    // Stray even byte and lone odd byte finish together; the single slot keeps the older one.
                    cw         = held_w;
                    extra_drop = 1'b1;
                end else begin
                    cw.sel = byte_sel;
                    cw.a   = byte_a;
                    cw.d   = {ioctl_dout, 8'h00};
                    cw.ds  = 2'b10;
                end
            end
        end else if (downl_fall && asm_valid) begin
            cw          = held_w;
            cw_valid    = 1'b1;
            asm_valid_d = 1'b0;
        end
    end

    assign ack_done = ((sd.port_ack ^ req_q) & cur_sel) == '0;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: if (slot_full) begin
                issue   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: if (ack_done) begin
                if (slot_full) issue = 1'b1;
                else           state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            downl_q      <= 1'b0;
            asm_valid    <= 1'b0;
            asm_sel      <= '0;
            asm_a        <= '0;
            asm_byte     <= '0;
            slot_full    <= 1'b0;
            slot         <= '0;
            req_q        <= '0;
            cur_sel      <= '0;
            a_q          <= '0;
            d_q          <= '0;
            ds_q         <= '0;
            we_q         <= 1'b0;
            overflow_q   <= 1'b0;
            dl_seen      <= 1'b0;
            rom_loaded_q <= 1'b0;
            count_q      <= RESET_CYCLES;
            core_reset_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_q      <= ioctl_wr;
            downl_q   <= ioctl_downl;
            asm_valid <= asm_valid_d;
            if (asm_load) begin
                asm_sel  <= byte_sel;
                asm_a    <= byte_a;
                asm_byte <= ioctl_dout;
            end

            if (cw_valid && (!slot_full || issue)) begin
                slot      <= cw;
                slot_full <= 1'b1;
            end else if (issue) begin
                slot_full <= 1'b0;
            end

            if (issue) begin
                a_q     <= slot.a;
                d_q     <= slot.d;
                ds_q    <= slot.ds;
                req_q   <= req_q ^ slot.sel;
                cur_sel <= slot.sel;
                we_q    <= 1'b1;
            end else if (state_q == S_WAIT && ack_done) begin
                we_q <= 1'b0;
            end

            if (downl_rise) overflow_q <= 1'b0;
            if ((cw_valid && slot_full && !issue) || extra_drop) overflow_q <= 1'b1;

            if (ioctl_downl && ioctl_index == ROM_INDEX) dl_seen <= 1'b1;
            if (dl_seen && !ioctl_downl && !dl_busy) rom_loaded_q <= 1'b1;

            if (soft_reset || !rom_loaded_q) count_q <= RESET_CYCLES;
            else if (count_q != 16'd0)       count_q <= count_q - 16'd1;
            core_reset_q <= (count_q != 16'd0);
        end
    end

    assign dl_busy    = asm_valid || slot_full || (state_q == S_WAIT);
    assign overflow   = overflow_q;
    assign rom_loaded = rom_loaded_q;
    assign core_reset = core_reset_q;

    assign sd.port_req = req_q;
    assign sd.port_a   = a_q;
    assign sd.port_d   = d_q;
    assign sd.port_ds  = ds_q;
    assign sd.port_we  = we_q;
endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router: packing, routing, queue/overflow, rom_loaded, core_reset and async reset.
module tb_rom_dl_router;
    localparam logic [15:0] RC = 16'd8;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_downl = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        soft_reset = 1'b0;
    logic        dl_busy, overflow, rom_loaded, core_reset;

    int n_cmp = 0;
    int n_bad = 0;

    rom_dl_router_if #(.NUM_PORTS(2), .PORT_AW(23)) sd ();

    rom_dl_router #(.NUM_PORTS(2), .PORT_AW(23), .RESET_CYCLES(RC)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .soft_reset  (soft_reset),
        .sd          (sd),
        .dl_busy     (dl_busy),
        .overflow    (overflow),
        .rom_loaded  (rom_loaded),
        .core_reset  (core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},   32'(sd.port_req), 32'h0);
        check({tag, "_we"},    32'(sd.port_we),  32'h0);
        check({tag, "_a"},     32'(sd.port_a),   32'h0);
        check({tag, "_d"},     32'(sd.port_d),   32'h0);
        check({tag, "_ds"},    32'(sd.port_ds),  32'h0);
        check({tag, "_busy"},  32'(dl_busy),     32'h0);
        check({tag, "_ovf"},   32'(overflow),    32'h0);
        check({tag, "_ldd"},   32'(rom_loaded),  32'h0);
        check({tag, "_creset"}, 32'(core_reset), 32'h1);
    endtask

    initial begin
        sd.port_ack = 2'b00;
        // Reset values
        repeat (3) tick();
        check_reset_state("rst");
        reset_n = 1'b1;
        tick();

        // Foreign index: ignored entirely
        ioctl_index = 8'h01;
        ioctl_downl = 1'b1;
        tick();
        send_byte(25'h0, 8'h11);
        send_byte(25'h1, 8'h22);
        check("idx1_req",  32'(sd.port_req), 32'h0);
        check("idx1_we",   32'(sd.port_we),  32'h0);
        check("idx1_busy", 32'(dl_busy),     32'h0);
        ioctl_downl = 1'b0;
        repeat (3) tick();
        check("idx1_ldd",    32'(rom_loaded), 32'h0);
        check("idx1_creset", 32'(core_reset), 32'h1);

        // Full word to port 0
        ioctl_index = 8'h00;
        ioctl_downl = 1'b1;
        tick();
        send_byte(25'h0, 8'h11);
        send_byte(25'h1, 8'h22);
        check("w0_req",  32'(sd.port_req), 32'h1);
        check("w0_a",    32'(sd.port_a),   32'h0);
        check("w0_d",    32'(sd.port_d),   32'h2211);
        check("w0_ds",   32'(sd.port_ds),  32'h3);
        check("w0_we",   32'(sd.port_we),  32'h1);
        check("w0_busy", 32'(dl_busy),     32'h1);
        sd.port_ack = 2'b01;
        tick();
        check("w0_we_ack",   32'(sd.port_we), 32'h0);
        check("w0_busy_ack", 32'(dl_busy),    32'h0);

        // Full word to port 1 at its base
        send_byte(25'h10000, 8'h33);
        send_byte(25'h10001, 8'h44);
        check("w1_req", 32'(sd.port_req), 32'h3);
        check("w1_a",   32'(sd.port_a),   32'h0);
        check("w1_d",   32'(sd.port_d),   32'h4433);
        sd.port_ack = 2'b11;
        tick();
        check("w1_we_ack", 32'(sd.port_we), 32'h0);

        // Lone even byte flushed when the download ends
        send_byte(25'h4, 8'hAA);
        check("fl_busy_held", 32'(dl_busy),     32'h1);
        check("fl_req_held",  32'(sd.port_req), 32'h3);
        ioctl_downl = 1'b0;
        tick();
        tick();
        check("fl_req", 32'(sd.port_req), 32'h2);
        check("fl_a",   32'(sd.port_a),   32'h2);
        check("fl_ds",  32'(sd.port_ds),  32'h1);
        check("fl_d",   32'(sd.port_d),   32'h00AA);
        check("fl_we",  32'(sd.port_we),  32'h1);
        sd.port_ack = 2'b10;
        tick();
        check("fl_we_ack", 32'(sd.port_we), 32'h0);
        check("fl_ldd_early", 32'(rom_loaded), 32'h0);
        tick();
        check("fl_ldd", 32'(rom_loaded), 32'h1);

        // core_reset: release after load, then soft_reset pulse and exact release latency
        repeat (12) tick();
        check("cr_low", 32'(core_reset), 32'h0);
        soft_reset = 1'b1;
        tick();
        tick();
        check("cr_soft_high", 32'(core_reset), 32'h1);
        soft_reset = 1'b0;
        repeat (int'(RC)) tick();
        check("cr_still_high", 32'(core_reset), 32'h1);
        tick();
        check("cr_fall", 32'(core_reset), 32'h0);
        check("cr_ldd_sticky", 32'(rom_loaded), 32'h1);

        // Withheld ack: second word queued, third dropped
        ioctl_downl = 1'b1;
        tick();
        send_byte(25'h8, 8'h01);
        send_byte(25'h9, 8'h02);
        check("q_req_a", 32'(sd.port_req), 32'h3);
        send_byte(25'hA, 8'h03);
        send_byte(25'hB, 8'h04);
        send_byte(25'hC, 8'h05);
        send_byte(25'hD, 8'h06);
        check("q_ovf",    32'(overflow),    32'h1);
        check("q_a_hold", 32'(sd.port_a),   32'h4);
        check("q_d_hold", 32'(sd.port_d),   32'h0201);
        check("q_busy",   32'(dl_busy),     32'h1);
        sd.port_ack = 2'b11;
        tick();
        check("q_req_b", 32'(sd.port_req), 32'h2);
        check("q_a_b",   32'(sd.port_a),   32'h5);
        check("q_d_b",   32'(sd.port_d),   32'h0403);
        check("q_we_b",  32'(sd.port_we),  32'h1);
        sd.port_ack = 2'b10;
        tick();
        check("q_we_done", 32'(sd.port_we), 32'h0);
        repeat (3) tick();
        check("q_no_third_we",  32'(sd.port_we),  32'h0);
        check("q_no_third_req", 32'(sd.port_req), 32'h2);
        check("q_idle_busy",    32'(dl_busy),     32'h0);
        ioctl_downl = 1'b0;
        tick();
        ioctl_downl = 1'b1;
        tick();
        check("q_ovf_clear", 32'(overflow), 32'h0);

        // Address past BASE_2 with two ports still lands in region 1
        send_byte(25'h20000, 8'h55);
        send_byte(25'h20001, 8'h66);
        check("hi_req", 32'(sd.port_req), 32'h0);
        check("hi_a",   32'(sd.port_a),   32'h8000);
        check("hi_d",   32'(sd.port_d),   32'h6655);
        sd.port_ack = 2'b00;
        tick();
        check("hi_we_ack", 32'(sd.port_we), 32'h0);

        // Async reset in the middle of a write
        send_byte(25'hE, 8'h77);
        send_byte(25'hF, 8'h88);
        check("mr_req_pre", 32'(sd.port_req), 32'h1);
        check("mr_we_pre",  32'(sd.port_we),  32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("mr");
        sd.port_ack = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
